std_mem_d1_reader: RTL and testbench

STD_MEM_D1_READER -- requirements
Module: std_mem_d1_reader

---
 rtl/std_mem_d1_reader.sv | 114 +++++++++++
 tb/tb_std_mem_d1_reader.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/std_mem_d1_reader.sv
// Streams a contiguous, wrapping range of std_mem_d1 entries out over a valid/ready port.
// One element per cycle under continuous ready; a single-cycle done pulse closes each run.
module std_mem_d1_reader #(
  parameter int unsigned width    = 32,
  parameter int unsigned size     = 16,
  parameter int unsigned idx_size = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                go,
  input  logic [idx_size-1:0] base,
  input  logic [idx_size:0]   len,
  output logic [idx_size-1:0] mem_addr0,
  input  logic [width-1:0]    mem_read_data,
  output logic [width-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                done
);

  localparam int unsigned CNT_W = idx_size + 1;
  localparam logic [CNT_W-1:0]    SIZE_C  = CNT_W'(size);
  localparam logic [idx_size-1:0] PTR_MAX = idx_size'(size - 1);

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_e;

  state_e              state_q, state_d;
  logic [idx_size-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0]    rem_q, rem_d;
  logic [width-1:0]    out_data_q, out_data_d;
  logic                out_valid_q, out_valid_d;
  logic                done_q, done_d;

  logic [idx_size-1:0] ptr_inc;
  logic [idx_size-1:0] base_fold;
  logic [CNT_W-1:0]    len_clamp;

  // Modulo-size pointer arithmetic keeps every address below size.
  always_comb begin
    ptr_inc   = (ptr_q == PTR_MAX) ? '0 : ptr_q + idx_size'(1);
    base_fold = ({1'b0, base} >= SIZE_C) ? idx_size'({1'b0, base} - SIZE_C) : base;
    len_clamp = (len > SIZE_C) ? SIZE_C : len;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    rem_d       = rem_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        out_valid_d = 1'b0;
        if (go) begin
          if (len != '0) begin
            ptr_d   = base_fold;
            rem_d   = len_clamp;
            state_d = LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end
      LOAD: begin
        out_data_d  = mem_read_data;
        out_valid_d = 1'b1;
        ptr_d       = ptr_inc;
        rem_d       = rem_q - CNT_W'(1);
        state_d     = SEND;
      end
      SEND: begin
        if (out_ready) begin
          if (rem_q != '0) begin
            out_data_d = mem_read_data;
            ptr_d      = ptr_inc;
            rem_d      = rem_q - CNT_W'(1);
          end else begin
            out_valid_d = 1'b0;
            done_d      = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      rem_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      rem_q       <= rem_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign mem_addr0 = ptr_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign done      = done_q;

endmodule

// File: tb/tb_std_mem_d1_reader.sv
// Randomized bench for std_mem_d1_reader with a behavioural memory and an expected-stream model.
module tb_std_mem_d1_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic        go;
  logic [3:0]  base;
  logic [4:0]  len;
  logic [3:0]  mem_addr0;
  logic [31:0] mem_read_data;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        done;

  logic [31:0] mem [16];
  int unsigned checks = 0;
  int unsigned errors = 0;

  assign mem_read_data = mem[mem_addr0];

  always #5 clk = ~clk;

  std_mem_d1_reader #(.width(32), .size(16), .idx_size(4)) dut (
    .clk(clk), .reset(reset), .go(go), .base(base), .len(len),
    .mem_addr0(mem_addr0), .mem_read_data(mem_read_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .done(done)
  );

  // One run from go (cycle 0) to done plus one trailing cycle.
  // mode 0: ready always 1; mode 1: random ready; mode 2: ready 1,0,0,1,1 from cycle 2, then 1.
  task automatic run(input int b, input int l, input int mode, input bit hold, input int nb, input int nl);
    logic [31:0] exp_q[$];
    int n, c, hs, last_hs, first_v;
    bit fin;
    for (int i = 0; i < 16; i++) mem[i] = 32'(i + 100);
    n = (l > 16) ? 16 : l;
    for (int i = 0; i < n; i++) exp_q.push_back(mem[(b + i) % 16]);
    go = 1'b1; base = 4'(b); len = 5'(l); out_ready = 1'b1;
    c = 0; hs = 0; last_hs = 0; first_v = -1; fin = 1'b0;
    while (!fin && c < 300) begin
      @(posedge clk); #1; c++;
      if (!hold) go = 1'b0;
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = !(c == 3 || c == 4);
      endcase
      if (out_valid) begin
        if (first_v < 0) first_v = c;
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL extra_valid b=%0d l=%0d: got data %0d expected no valid", b, l, out_data);
        end else if (out_data !== exp_q[0]) begin
          errors++; $display("FAIL data b=%0d l=%0d idx=%0d: got %0d expected %0d", b, l, hs, out_data, exp_q[0]);
        end
        checks++;
        if (mem_addr0 !== 4'((b + hs + 1) % 16)) begin
          errors++; $display("FAIL addr b=%0d l=%0d: got %0d expected %0d", b, l, mem_addr0, (b + hs + 1) % 16);
        end
        if (out_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          hs++; last_hs = c;
        end else if (mode != 0) begin
          mem[(b + hs) % 16] = $urandom;
        end
      end
      if (done) begin
        fin = 1'b1;
        checks++;
        if (exp_q.size() != 0) begin
          errors++; $display("FAIL count b=%0d l=%0d: got %0d elements expected %0d", b, l, hs, n);
        end
        checks++;
        if (c != ((n == 0) ? 1 : last_hs + 1)) begin
          errors++; $display("FAIL done_cycle b=%0d l=%0d: got %0d expected %0d", b, l, c, (n == 0) ? 1 : last_hs + 1);
        end
        if (mode == 0 && n > 0) begin
          checks++;
          if (first_v != 2) begin
            errors++; $display("FAIL first_valid b=%0d l=%0d: got %0d expected 2", b, l, first_v);
          end
        end
        if (hold) begin base = 4'(nb); len = 5'(nl); end
      end
    end
    if (!fin) begin
      errors++; $display("FAIL timeout b=%0d l=%0d: got no done expected done", b, l);
    end
    @(posedge clk); #1;
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL done_pulse b=%0d l=%0d: got done=%0b valid=%0b expected 0 0", b, l, done, out_valid);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; base = '0; len = '0; out_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = 32'(i + 100);
    #12;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || mem_addr0 !== 4'd0 || out_data !== 32'd0) begin
      errors++; $display("FAIL reset_state: got v=%0b d=%0b a=%0d o=%0d expected 0 0 0 0", out_valid, done, mem_addr0, out_data);
    end
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 16; i++) mem[i] = 32'(i + 100);
    go = 1'b1; base = 4'd5; len = 5'd5; out_ready = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1; go = 1'b0;
    end
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'd107) begin
      errors++; $display("FAIL pre_reset: got v=%0b o=%0d expected 1 107", out_valid, out_data);
    end
    reset = 1'b1; #1;
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || mem_addr0 !== 4'd0) begin
      errors++; $display("FAIL async_reset: got v=%0b d=%0b a=%0d expected 0 0 0", out_valid, done, mem_addr0);
    end
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL post_reset_idle: got v=%0b d=%0b expected 0 0", out_valid, done);
      end
    end
    run(9, 3, 0, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    for (int r = 0; r < 25; r++) run($urandom_range(0, 15), $urandom_range(0, 31), 1, 1'b0, 0, 0);
  endtask

  initial begin
    test_reset();
    run(3, 4, 0, 1'b0, 0, 0);            // basic
    run(14, 4, 0, 1'b0, 0, 0);           // wrap
    run(7, 0, 0, 1'b0, 0, 0);            // len zero
    run(5, 20, 0, 1'b0, 0, 0);           // clamp to size
    run(0, 3, 2, 1'b0, 0, 0);            // stall pattern
    run(2, 2, 0, 1'b1, 10, 3);           // back-to-back with go held
    run(10, 3, 0, 1'b0, 0, 0);
    test_random();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
